s510_cnt_gen: RTL

S510_CNT_GEN -- requirements
Module: s510_cnt_gen

---
 rtl/s510_cnt_gen.sv | 112 +++++++++++
 1 files changed

// File: rtl/s510_cnt_gen.sv
// s510_cnt_gen -- prescaled 10-bit event counter with fixed-count decodes.
//
// A 3-bit prescaler cycles 0..6 while enabled. The main counter advances once
// per prescaler wrap, so it steps once every 7 enabled clocks. The main
// counter saturates at 1023. Every output is a decode of registered state
// only, so there is no path from any input to any output.
//
// Optional feature: define S510_CNT_OVF_EN to add the sticky cnt_ovf port.
// It sets on the first enabled prescaler wrap seen while the count is
// saturated. It clears only on reset or cnt_clr. When the macro is undefined,
// the port and its register do not exist.

module s510_cnt_gen (
    input  logic clock,
    input  logic reset,
    input  logic cnt_clr,
    input  logic cnt_en,
    output logic pcnt6,
    output logic cnt10,
    output logic cnt21,
    output logic cnt44,
    output logic cnt45,
    output logic cnt261,
    output logic cnt272,
    output logic cnt283,
    output logic cnt284,
    output logic cnt509,
    output logic cnt511,
    output logic cnt567,
    output logic cnt591,
`ifdef S510_CNT_OVF_EN
    output logic cnt_ovf,
`endif
    output logic cnt_sat
);

    localparam logic [2:0] PCNT_LAST = 3'd6;
    localparam logic [9:0] CNT_MAX   = 10'd1023;

    logic [2:0] pcnt;
    logic [9:0] count;
    logic       pwrap;
    logic       at_max;

    // A wrap only counts on an enabled clock. cnt_clr has priority over the
    // wrap, and that priority is applied inside the register blocks below.
    assign pwrap  = cnt_en && (pcnt == PCNT_LAST);
    assign at_max = (count == CNT_MAX);

    // Prescaler: 0..6 then back to 0. It keeps cycling even when the main
    // counter is saturated.
    always_ff @(posedge clock) begin
        if (reset) begin
            pcnt <= 3'd0;
        end else if (cnt_clr) begin
            pcnt <= 3'd0;
        end else if (cnt_en) begin
            if (pwrap) begin
                pcnt <= 3'd0;
            end else begin
                pcnt <= pcnt + 3'd1;
            end
        end
    end

    // Main counter: steps on each prescaler wrap and holds at 1023 instead of
    // wrapping to 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= 10'd0;
        end else if (cnt_clr) begin
            count <= 10'd0;
        end else if (pwrap && !at_max) begin
            count <= count + 10'd1;
        end
    end

`ifdef S510_CNT_OVF_EN
    logic ovf;

    // Sticky overflow flag: set by a wrap that would have taken the count
    // past 1023.
    always_ff @(posedge clock) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (cnt_clr) begin
            ovf <= 1'b0;
        end else if (pwrap && at_max) begin
            ovf <= 1'b1;
        end
    end

    assign cnt_ovf = ovf;
`endif

    // Output decodes of the registered prescaler and counter values.
    assign pcnt6   = (pcnt == PCNT_LAST);
    assign cnt10   = (count == 10'd10);
    assign cnt21   = (count == 10'd21);
    assign cnt44   = (count == 10'd44);
    assign cnt45   = (count == 10'd45);
    assign cnt261  = (count == 10'd261);
    assign cnt272  = (count == 10'd272);
    assign cnt283  = (count == 10'd283);
    assign cnt284  = (count == 10'd284);
    assign cnt509  = (count == 10'd509);
    assign cnt511  = (count == 10'd511);
    assign cnt567  = (count == 10'd567);
    assign cnt591  = (count == 10'd591);
    assign cnt_sat = at_max;

endmodule
